data_memory_responder: RTL and testbench

Handshaked data-memory responder: the memory end of the core's load/store port. It accepts one load or store request at a time and holds it for a fixed number of wait states. It then performs a little-endian byte, half or word access on an internal word array and returns sign- or zero-extended load data, or an error flag, through a valid/ready response channel. It sits between the core's load/store path and a word-organised RAM, so the core can be moved from an ideal zero-latency memory to a memory with real latency.

---
 rtl/data_memory_responder.sv | 188 ++++++++++++++++++
 tb/tb_data_memory_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Handshaked load/store responder over a word-organised RAM with little-endian lane access.
// Define DATA_MEMORY_RESPONDER_WAIT_EN to insert WAIT_CYCLES wait states before each response.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
    logic [CNT_W-1:0] r_cnt;
`else
    typedef enum logic [1:0] {StIdle, StResp} state_e;
`endif

    state_e      r_state;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_rdata;
    logic        r_error;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_a_write;
    logic [31:0]      w_a_addr;
    logic [31:0]      w_a_wdata;
    logic [1:0]       w_a_size;
    logic             w_a_unsigned;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_wrep;
    logic [3:0]       w_be;
    logic             w_commit;

    assign w_accept = req_valid && (r_state == StIdle);

`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == StWait) && (r_cnt == '0));
`else
    assign w_enter_resp = w_accept;
`endif

    // A zero-wait accept performs the access on the capture edge, so it must use the live fields.
    assign w_a_write    = (r_state == StIdle) ? req_write    : r_write;
    assign w_a_addr     = (r_state == StIdle) ? req_addr     : r_addr;
    assign w_a_wdata    = (r_state == StIdle) ? req_wdata    : r_wdata;
    assign w_a_size     = (r_state == StIdle) ? req_size     : r_size;
    assign w_a_unsigned = (r_state == StIdle) ? req_unsigned : r_unsigned;

    assign w_err = (w_a_size == 2'b11) ||
                   ((w_a_size == 2'b01) && w_a_addr[0]) ||
                   ((w_a_size == 2'b10) && (w_a_addr[1:0] != 2'b00)) ||
                   ({1'b0, w_a_addr} >= BYTE_LIMIT);

    assign w_idx     = w_a_addr[IDX_W+1:2];
    assign w_rd_word = r_mem[w_idx];
    assign w_byte    = w_rd_word[{w_a_addr[1:0], 3'b000} +: 8];
    assign w_half    = w_rd_word[{w_a_addr[1], 4'b0000} +: 16];
    assign w_commit  = w_enter_resp && w_a_write && !w_err;

    always_comb begin
        w_load = '0;
        w_wrep = w_a_wdata;
        w_be   = 4'b0000;
        case (w_a_size)
            2'b00: begin
                w_load = {{24{~w_a_unsigned & w_byte[7]}}, w_byte};
                w_wrep = {4{w_a_wdata[7:0]}};
                w_be   = 4'b0001 << w_a_addr[1:0];
            end
            2'b01: begin
                w_load = {{16{~w_a_unsigned & w_half[15]}}, w_half};
                w_wrep = {2{w_a_wdata[15:0]}};
                w_be   = w_a_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_load = w_rd_word;
                w_be   = 4'b1111;
            end
            default: begin
                w_load = '0;
                w_be   = 4'b0000;
            end
        endcase
    end

    // Memory contents survive reset; a reset on the commit edge still blocks the write.
    always_ff @(posedge clock) begin
        if (w_commit && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
            r_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
                        if (WAIT_CYCLES == 0) begin
                            r_state <= StResp;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
`else
                        r_state <= StResp;
`endif
                    end
                end
`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
                StWait: begin
                    if (r_cnt == '0) begin
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                StResp: begin
                    if (rsp_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase

            if (w_enter_resp) begin
                r_rdata <= (w_err || w_a_write) ? 32'h0 : w_load;
                r_error <= w_err;
            end
        end
    end

    assign req_ready = (r_state == StIdle);
    assign rsp_valid = (r_state == StResp);
    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed vector table, corner sequences,
// and randomized traffic against a byte-array reference model.
module tb_data_memory_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WCYC  = 2;
`ifdef DATA_MEMORY_RESPONDER_WAIT_EN
    localparam int LAT = WCYC;
`else
    localparam int LAT = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m [DEPTH*4];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [16];

    data_memory_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WCYC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error)
    );

    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory with the access rules applied directly.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] sz, input logic u,
                                output logic [31:0] rd, output logic er);
        int nb;
        logic [31:0] val;
        nb  = 1 << sz;
        er  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
              (a >= DEPTH * 4);
        rd  = 32'h0;
        val = 32'h0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < nb; i++) m[int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) val = val | (32'(m[int'(a) + i]) << (8 * i));
                if (!u && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
                rd = val;
            end
        end
    endtask

    // Starts at #1 after an edge with the DUT idle; returns #1 after the handshake edge.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic u, input int stall,
                          output logic [31:0] rd, output logic er);
        int lat;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = u;
        rsp_ready = (stall == 0);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
            if (lat == 1) req_valid = 1'b0;
        end while (!rsp_valid && lat < 64);
        check_int("latency", lat, 1 + LAT);
        rd = rsp_rdata;
        er = rsp_error;
        for (int s = 0; s < stall; s++) begin
            @(posedge clock); #1;
            check32("stall_valid", {31'b0, rsp_valid}, 32'h1);
            check32("stall_rdata", rsp_rdata, rd);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        logic [31:0] rd, mrd, a;
        logic        er, mer, w, u;
        logic [1:0]  sz;
        int          t [10];
        int          n, cyc, stall;

        tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h13,  32'h80,       2'b00, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h14,  32'h8001,     2'b01, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h13,  32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0};
        tbl[5]  = '{1'b0, 32'h13,  32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0};
        tbl[6]  = '{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0};
        tbl[7]  = '{1'b0, 32'h14,  32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0};
        tbl[8]  = '{1'b0, 32'h11,  32'h0,        2'b01, 1'b0, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0};
        tbl[10] = '{1'b1, 32'h12,  32'h12345678, 2'b10, 1'b0, 32'h0,        1'b1};
        tbl[11] = '{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0};
        tbl[12] = '{1'b0, 32'h10,  32'h0,        2'b11, 1'b0, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0};
        tbl[14] = '{1'b0, 32'h400, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1};
        tbl[15] = '{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'b10; req_unsigned = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check32("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check32("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check32("rst_rsp_rdata", rsp_rdata, 32'h0);
        check32("rst_rsp_error", {31'b0, rsp_error}, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 16; i++) begin
            do_txn(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].sz, tbl[i].u, 0, rd, er);
            model_access(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].sz, tbl[i].u, mrd, mer);
            check32($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check32($sformatf("tbl%0d_error", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
        end

        // Backpressure: response must hold and a competing store must be ignored.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10;
        rsp_ready = 1'b0;
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 1) req_valid = 1'b0;
        end while (!rsp_valid && cyc < 64);
        check_int("bp_latency", cyc, 1 + LAT);
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0BAD0BAD;
        for (int s = 0; s < 5; s++) begin
            @(posedge clock); #1;
            check32("bp_valid", {31'b0, rsp_valid}, 32'h1);
            check32("bp_rdata", rsp_rdata, 32'h80ADBEEF);
            check32("bp_error", {31'b0, rsp_error}, 32'h0);
            check32("bp_req_ready", {31'b0, req_ready}, 32'h0);
        end
        req_valid = 1'b0; req_write = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        check32("bp_release_valid", {31'b0, rsp_valid}, 32'h0);
        check32("bp_release_ready", {31'b0, req_ready}, 32'h1);
        do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
        check32("bp_no_intruder", rd, 32'h80ADBEEF);

        // Reset during the wait window discards the store; without wait states it already landed.
        do_txn(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 0, rd, er);
        model_access(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, mrd, mer);
        do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111;
        req_size = 2'b10;
        @(posedge clock); #1;
        req_valid = 1'b0; req_write = 1'b0;
        reset = 1'b1;
        #1;
        check32("mid_rst_req_ready", {31'b0, req_ready}, 32'h1);
        check32("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check32("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
        check32("mid_rst_rsp_error", {31'b0, rsp_error}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        if (LAT == 0) model_access(1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, mrd, mer);
        do_txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, rd, er);
        check32("mid_rst_reload", rd, (LAT > 0) ? 32'hCAFEF00D : 32'h11111111);

        // Fill every word so random loads have a known reference.
        for (int i = 0; i < DEPTH; i++) begin
            a = $urandom;
            do_txn(1'b1, 32'(i * 4), a, 2'b10, 1'b0, 0, rd, er);
            model_access(1'b1, 32'(i * 4), a, 2'b10, 1'b0, mrd, mer);
        end

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_0400;
            else a = 32'($urandom_range(0, DEPTH * 4 - 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_txn(w, a, $urandom, sz, u, stall, rd, er);
            model_access(w, a, req_wdata, sz, u, mrd, mer);
            check32($sformatf("rnd%0d_rdata", i), rd, mrd);
            check32($sformatf("rnd%0d_error", i), {31'b0, er}, {31'b0, mer});
        end

        // Back-to-back loads with req_valid held: response spacing is the transaction period.
        model_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, mrd, mer);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10;
        rsp_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 10 && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            if (rsp_valid) begin
                t[n] = cyc;
                check32("tp_rdata", rsp_rdata, mrd);
                n++;
                if (n == 10) req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        @(posedge clock); #1;
        check_int("tp_count", n, 10);
        for (int i = 1; i < n; i++) check_int("tp_interval", t[i] - t[i-1], LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
